// File: rtl/hack_alu_pipe.sv
// Registered, WIDTH-generic Hack ALU with shift modes, a multi-cycle unsigned
// multiplier, carry/overflow flags and a single-entry output register.
module hack_alu_pipe #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov,
  output logic             busy
);

  localparam logic [1:0] MODE_HACK = 2'b00;
  localparam logic [1:0] MODE_MUL  = 2'b01;
  localparam logic [1:0] MODE_LSL  = 2'b10;
  localparam logic [1:0] MODE_ASR  = 2'b11;

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [2*WIDTH-1:0]   acc;
  logic [SHW-1:0]       cnt;

  logic                 accept;
  logic                 mul_done;
  logic                 load;
  logic [SHW-1:0]       amt;
  logic [WIDTH-1:0]     x1, x2, y1, y2, hack_r;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shl;
  logic signed [WIDTH:0] shr;
  logic [2*WIDTH-1:0]   mul_sum;
  logic [WIDTH-1:0]     res_out;
  logic                 res_cy;
  logic                 res_ov;

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; ready never depends on the same side's valid.
  assign in_ready = (state == IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign busy     = (state == MUL);
  assign mul_done = (state == MUL) & (cnt == SHW'(WIDTH - 1));
  assign load     = mul_done | (accept & (mode != MODE_MUL));
  assign amt      = y[SHW-1:0];

  always_comb begin
    x1      = ctrl[5] ? '0 : x;
    x2      = ctrl[4] ? ~x1 : x1;
    y1      = ctrl[3] ? '0 : y;
    y2      = ctrl[2] ? ~y1 : y1;
    sum     = {1'b0, x2} + {1'b0, y2};
    hack_r  = ctrl[1] ? sum[WIDTH-1:0] : (x2 & y2);
    // The extra LSB/MSB catches the last bit shifted out as the carry.
    shl     = {1'b0, x} << amt;
    shr     = $signed({x, 1'b0}) >>> amt;
    mul_sum = acc + (mul_b[0] ? mul_a : '0);
    res_out = '0;
    res_cy  = 1'b0;
    res_ov  = 1'b0;
    if (state == MUL) begin
      res_out = mul_sum[WIDTH-1:0];
      res_ov  = |mul_sum[2*WIDTH-1:WIDTH];
    end else begin
      case (mode)
        MODE_HACK: begin
          res_out = ctrl[0] ? ~hack_r : hack_r;
          res_cy  = ctrl[1] & sum[WIDTH];
          res_ov  = ctrl[1] & (x2[WIDTH-1] == y2[WIDTH-1])
                            & (sum[WIDTH-1] != x2[WIDTH-1]);
        end
        MODE_LSL: begin
          res_out = shl[WIDTH-1:0];
          res_cy  = shl[WIDTH];
        end
        MODE_ASR: begin
          res_out = shr[WIDTH:1];
          res_cy  = shr[0];
        end
        default: begin
          res_out = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      cy        <= 1'b0;
      ov        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        out       <= res_out;
        zr        <= (res_out == '0);
        ng        <= res_out[WIDTH-1];
        cy        <= res_cy;
        ov        <= res_ov;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept && mode == MODE_MUL) begin
            mul_a <= {{WIDTH{1'b0}}, x};
            mul_b <= y;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          // One multiplier bit per edge, LSB first.
          acc   <= mul_sum;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + SHW'(1);
          if (mul_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Bench for hack_alu_pipe: directed plan vectors, backpressure and reset
// scenarios, then randomized traffic against an arithmetic reference model.
module tb_hack_alu_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [5:0]   ctrl = '0;
  logic [1:0]   mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         zr, ng, cy, ov, busy;

  logic [W+3:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  bit           rand_bp = 1'b0;

  always #5 clk = ~clk;

  hack_alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zr(zr), .ng(ng), .cy(cy), .ov(ov),
    .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W+3:0] rec(input logic [W-1:0] o, input logic z,
                                       input logic n, input logic c, input logic v);
    return {o, z, n, c, v};
  endfunction

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [5:0] c, input logic [1:0] m);
    longint unsigned lim = 64'd1 << W;
    longint unsigned ua, ub, p;
    longint          sa, sb, s;
    logic [W-1:0]    o;
    logic            cyv, ovv;
    int              sh;
    cyv = 1'b0;
    ovv = 1'b0;
    sh  = int'(b) % W;
    ua  = a;
    ub  = b;
    o   = '0;
    case (m)
      2'd0: begin
        if (c[5]) ua = 0;
        if (c[4]) ua = (lim - 1) - ua;
        if (c[3]) ub = 0;
        if (c[2]) ub = (lim - 1) - ub;
        if (c[1]) begin
          p   = ua + ub;
          cyv = (p >= lim);
          sa  = (ua >= lim / 2) ? longint'(ua) - longint'(lim) : longint'(ua);
          sb  = (ub >= lim / 2) ? longint'(ub) - longint'(lim) : longint'(ub);
          s   = sa + sb;
          ovv = (s > longint'(lim / 2) - 1) || (s < -longint'(lim / 2));
          p   = p % lim;
        end else begin
          p = ua & ub;
        end
        if (c[0]) p = (lim - 1) - p;
        o = W'(p);
      end
      2'd1: begin
        p   = ua * ub;
        o   = W'(p % lim);
        ovv = (p / lim) != 0;
      end
      2'd2: begin
        p   = ua * (64'd1 << sh);
        o   = W'(p % lim);
        cyv = (sh != 0) && ((p / lim) % 2 == 1);
      end
      default: begin
        sa  = (ua >= lim / 2) ? longint'(ua) - longint'(lim) : longint'(ua);
        s   = sa >>> sh;
        o   = W'(s);
        cyv = (sh != 0) && ((ua / (64'd1 << (sh - 1))) % 2 == 1);
      end
    endcase
    return {o, (o == '0), o[W-1], cyv, ovv};
  endfunction

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] c,
                       input logic [1:0] m, input bit push, input logic [W+3:0] e);
    bit acc = 1'b0;
    x = a; y = b; ctrl = c; mode = m; in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom); ctrl = 6'($urandom); mode = 2'($urandom);
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end else if (push) begin
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: every output handshake consumes one expected record.
  initial begin
    logic [W+3:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got %0h expected no output", out);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'({out, zr, ng, cy, ov}), 64'(e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2 ms");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int lat;
    int nvalid;
    bit ok;
    logic [W-1:0] a, b;
    logic [5:0]   c;
    logic [1:0]   m;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 64'(out), 64'd0);
    check("reset_flags", 64'({zr, ng, cy, ov}), 64'd0);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    issue(16'd5, 16'd3, 6'b000010, 2'b00, 1, rec(16'd8, 0, 0, 0, 0));
    issue(16'd5, 16'd3, 6'b010011, 2'b00, 1, rec(16'd2, 0, 0, 0, 0));
    issue(16'h1234, 16'h5678, 6'b111010, 2'b00, 1, rec(16'hFFFF, 0, 1, 0, 0));
    issue(16'h7FFF, 16'd1, 6'b000010, 2'b00, 1, rec(16'h8000, 0, 1, 0, 1));
    issue(16'hFFFF, 16'd1, 6'b000010, 2'b00, 1, rec(16'h0000, 1, 0, 1, 0));
    issue(16'h8001, 16'd1, 6'b101101, 2'b10, 1, rec(16'h0002, 0, 0, 1, 0));
    issue(16'h8000, 16'h0013, 6'b010101, 2'b11, 1, rec(16'hF000, 0, 1, 0, 0));

    issue(16'd300, 16'd300, 6'b000000, 2'b01, 1, rec(16'h5F90, 0, 0, 0, 1));
    ok  = busy && !in_ready;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      if (!busy || in_ready) ok = 1'b0;
    end
    check("mul_latency", 64'(lat), 64'd16);
    check("mul_busy_window", 64'(ok), 64'd1);
    check("mul_busy_clear", 64'(busy), 64'd0);
    issue(16'd3, 16'd4, 6'b000000, 2'b01, 1, rec(16'd12, 0, 0, 0, 0));
    drain();

    out_ready = 1'b0;
    issue(16'd5, 16'd3, 6'b000010, 2'b00, 1, rec(16'd8, 0, 0, 0, 0));
    x = 16'd7; y = 16'd2; ctrl = 6'b000010; mode = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold", 64'({out, zr, ng, cy, ov}), 64'(rec(16'd8, 0, 0, 0, 0)));
      check("bp_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    exp_q.push_back(rec(16'd9, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_out", 64'(out), 64'd9);
    drain();

    issue(16'd300, 16'd300, 6'b000000, 2'b01, 0, '0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_flags", 64'({zr, ng, cy, ov}), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    check("postrst_busy", 64'(busy), 64'd0);
    nvalid = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) nvalid++;
    end
    check("postrst_no_stale", 64'(nvalid), 64'd0);

    rand_bp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      m = 2'($urandom_range(0, 3));
      a = pick();
      b = (m[1] && $urandom_range(0, 1) == 1) ? W'($urandom_range(0, W + 3)) : pick();
      c = 6'($urandom_range(0, 63));
      issue(a, b, c, m, 1, model(a, b, c, m));
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
